// File: rtl/uart_rx_fifo_if.sv
// Valid/ready byte stream between the UART receive FIFO (master) and its consumer (slave).
interface uart_rx_fifo_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with programmable bit period feeding a show-ahead byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_fifo #(
  parameter int unsigned DEFAULT_DIV = 106,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned LEVEL_W     = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ser_rx,
  input  logic [15:0]        cfg_div,
  uart_rx_fifo_if.master     rx,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic               frame_err,
  output logic               overrun,
  output logic               parity_err
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitIdle
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, rxs_q;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [15:0] div_eff;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        expire;
  logic        push;
  logic        par_bad;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_q, rd_q;
  logic [LEVEL_W-1:0] count_q;
  logic               full, pop, do_push;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic parity_err_q, parity_err_d;
  assign par_bad    = ^{data_q, par_q};
  assign parity_err = parity_err_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign div_eff = (cfg_div < 16'd4) ? 16'(DEFAULT_DIV) : cfg_div;
  assign expire  = (cnt_q == 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      div_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= ser_rx;
      rxs_q       <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q > 16'd1) ? cnt_q - 16'd1 : cnt_q;
    div_d       = div_q;
    idx_d       = idx_q;
    data_d      = data_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          state_d = StStart;
          div_d   = div_eff;
          cnt_d   = div_eff >> 1;
        end
      end
      StStart: begin
        if (expire) begin
          if (rxs_q) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            cnt_d   = div_q;
            idx_d   = 3'd0;
          end
        end
      end
      StData: begin
        if (expire) begin
          data_d[idx_q] = rxs_q;
          cnt_d         = div_q;
          idx_d         = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (expire) begin
          par_d   = rxs_q;
          cnt_d   = div_q;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (expire) begin
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad;
`endif
          if (rxs_q) begin
            push    = !par_bad;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        // A held-low break line reports a single frame error, not one per bit time.
        if (rxs_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign full      = (count_q == LEVEL_W'(FIFO_DEPTH));
  assign pop       = rx.rx_valid && rx.rx_ready;
  // When full, a same-cycle pop frees the slot the incoming byte needs.
  assign do_push   = push && (!full || pop);
  assign overrun_d = push && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrW'(1);
      if (pop)     rd_q <= rd_q + PtrW'(1);
      if (do_push && !pop)      count_q <= count_q + LEVEL_W'(1);
      else if (pop && !do_push) count_q <= count_q - LEVEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_q;
  end

  assign rx.rx_valid = (count_q != '0);
  assign rx.rx_data  = rx.rx_valid ? mem_q[rd_q] : 8'h00;
  assign fifo_level  = count_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed frames, monitor checks every popped byte.
module tb_uart_rx_fifo;

  localparam int D = 106;
`ifdef UART_RX_PARITY_EN
  localparam int StopEdge = 1010 + D;
  localparam int PeExp    = 1;
`else
  localparam int StopEdge = 1010;
  localparam int PeExp    = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ser_rx;
  logic [15:0] cfg_div;
  logic [4:0]  fifo_level;
  logic        frame_err, overrun, parity_err;

  uart_rx_fifo_if bus ();

  uart_rx_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .ser_rx    (ser_rx),
    .cfg_div   (cfg_div),
    .rx        (bus),
    .fifo_level(fifo_level),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_err    = 0;
  int         fe_cnt   = 0;
  int         ov_cnt   = 0;
  int         pe_cnt   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
`ifdef UART_RX_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Line is left at the stop-bit value when the task returns.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int d);
    ser_rx = 1'b0;
    tick(d);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      tick(d);
    end
`ifdef UART_RX_PARITY_EN
    ser_rx = (^b) ^ par_flip;
    tick(d);
`endif
    ser_rx = stop;
    tick(d);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err)  fe_cnt++;
      if (overrun)    ov_cnt++;
      if (parity_err) pe_cnt++;
      if (bus.rx_valid && bus.rx_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_byte: got 0x%02h, expected no byte", bus.rx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (bus.rx_data !== exp_b) begin
            n_err++;
            $display("FAIL rx_data: got 0x%02h, expected 0x%02h", bus.rx_data, exp_b);
          end
        end
      end
    end
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    ser_rx       = 1'b1;
    cfg_div      = 16'd0;
    bus.rx_ready = 1'b0;
    tick(3);
    check("reset_valid", bus.rx_valid, 0);
    check("reset_level", fifo_level, 0);
    check("reset_data", bus.rx_data, 0);
    check("reset_pulses", {frame_err, overrun, parity_err}, 0);
    reset = 1'b0;
    tick(10);

    // Default divider, valid edge lands one cycle after the stop sample
    bus.rx_ready = 1'b1;
    exp_q.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1, D);
      begin
        tick(StopEdge - 1);
        check("valid_before_stop", bus.rx_valid, 0);
        tick(1);
        check("valid_after_stop", bus.rx_valid, 1);
      end
    join
    exp_q.push_back(8'hA3);
    send_frame(8'hA3, 1'b1, D);
    wait_drain("drain_55_a3");

    // Short programmed period
    cfg_div = 16'd16;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 16);
    tick(20);
    wait_drain("drain_div16");

    // Glitch on the line is rejected at the start-bit centre
    cfg_div = 16'd106;
    ser_rx  = 1'b0;
    tick(20);
    ser_rx  = 1'b1;
    tick(300);
    check("glitch_valid", bus.rx_valid, 0);
    check("glitch_fe", fe_cnt, 0);

    // Bad stop bit, line stays low two more bit times
    send_frame(8'h3C, 1'b0, D);
    tick(2 * D);
    ser_rx = 1'b1;
    tick(D);
    check("stop_low_fe", fe_cnt, 1);
    check("stop_low_level", fifo_level, 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, D);
    wait_drain("drain_7e");

    // Fill to capacity, 17th byte overruns
    bus.rx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, D);
    end
    check("full_level", fifo_level, 16);
    check("full_no_ov", ov_cnt, 0);
    send_frame(8'h10, 1'b1, D);
    check("ov_level", fifo_level, 16);
    check("ov_count", ov_cnt, 1);
    bus.rx_ready = 1'b1;
    wait_drain("drain_overrun");
    check("drained_level", fifo_level, 0);

    // Full FIFO with a pop on the exact stop-sample cycle
    bus.rx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(8'h20 + i));
      send_frame(8'(8'h20 + i), 1'b1, D);
    end
    exp_q.push_back(8'h99);
    fork
      send_frame(8'h99, 1'b1, D);
      begin
        tick(StopEdge - 1);
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
      end
    join
    check("simul_level", fifo_level, 16);
    check("simul_no_ov", ov_cnt, 1);
    bus.rx_ready = 1'b1;
    wait_drain("drain_simul");

    // Reset during bit 4 flushes the FIFO and abandons the frame
    bus.rx_ready = 1'b0;
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, D);
    check("pre_reset_level", fifo_level, 1);
    fork
      send_frame(8'hF0, 1'b1, D);
      begin
        tick(5 * D + 50);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        exp_q.delete();
        check("midreset_valid", bus.rx_valid, 0);
        check("midreset_level", fifo_level, 0);
        check("midreset_data", bus.rx_data, 0);
        check("midreset_pulses", {frame_err, overrun, parity_err}, 0);
      end
    join
    tick(D);
    check("post_reset_level", fifo_level, 0);
    bus.rx_ready = 1'b1;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, D);
    wait_drain("drain_81");

`ifdef UART_RX_PARITY_EN
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, D);
    wait_drain("drain_par_ok");
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, D);
    par_flip = 1'b0;
    tick(D);
    check("par_bad_level", fifo_level, 0);
`endif

    tick(20);
    check("final_fe", fe_cnt, 1);
    check("final_ov", ov_cnt, 1);
    check("final_pe", pe_cnt, PeExp);
    check("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Synthesizable UART receiver with a byte FIFO; consumes the SoC `ser_tx` serial stream, i.e. the stage directly downstream of the UART transmitter.
- Used as an on-chip loopback/debug monitor, e.g. to capture console output on a second FPGA pin.
- Replaces the behavioural sampler in the simulation bench with real RTL.
- 8N1 framing, LSB first, runtime-programmable bit period, valid/ready byte output.

Parameters:
- DEFAULT_DIV, 106, clocks per bit used when cfg_div < 4
- FIFO_DEPTH, 16, byte entries; power of two, >= 2
- LEVEL_W, 5, width of fifo_level; must hold FIFO_DEPTH

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ser_rx  in  1  asynchronous serial input, idle high
- cfg_div  in  16  clocks per bit; values 0..3 select DEFAULT_DIV
- rx_data  out  8  head-of-FIFO byte
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer accepts rx_data this cycle
- fifo_level  out  LEVEL_W  current entry count
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: byte dropped because FIFO full
- parity_err  out  1  one-cycle pulse: parity mismatch (see Optional Feature)

Behaviour:
- Reset values:
  - rx_valid = 0, fifo_level = 0, frame_err = overrun = parity_err = 0, rx_data = 0.
  - Synchronizer flops = 1; FSM = IDLE; FIFO pointers = 0.
- Reset mid-frame abandons the partial byte. Nothing is pushed.
- Input conditioning:
  - Two-flop synchronizer on ser_rx; all logic uses the second flop (rxs).
  - Bit period D = cfg_div, or DEFAULT_DIV if cfg_div < 4.
  - D is latched at start detection and held for the whole frame.
- FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE.
  - IDLE: rxs == 0 -> START; load counter with D/2 (floor).
  - START: on counter expiry, sample rxs.
    - rxs == 1 -> IDLE (glitch rejected, no error).
    - rxs == 0 -> DATA; load counter with D; bit index = 0.
  - DATA: on each expiry, shift rxs into bit[index] (LSB first); reload D.
    - After bit 7 -> PARITY if enabled, else STOP.
  - STOP: on expiry, sample rxs.
    - rxs == 1: push byte (unless parity error), then -> IDLE.
    - rxs == 0: frame_err pulse, byte dropped, -> WAIT_IDLE.
  - WAIT_IDLE: stay until rxs == 1 (break condition), then -> IDLE. A held-low line yields exactly one frame_err.
- Counter:
  - Down-counter; "expiry" = count reaches 1.
  - Every sample lands at bit centre ±1 clock.
- FIFO:
  - Show-ahead: rx_data is the head entry whenever rx_valid = 1.
  - Pop occurs on the clk edge where rx_valid && rx_ready.
  - Push happens on the stop-sample cycle. rx_valid and fifo_level reflect the new byte on the next cycle (1-cycle latency from stop sample).
  - Push while full and no pop: byte dropped, overrun pulses on the stop-sample cycle + 1, level stays FIFO_DEPTH.
  - Push while full with a simultaneous pop: both occur, level unchanged, no overrun.
  - Push into empty FIFO: the byte becomes visible the next cycle, never combinationally.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level saturates at FIFO_DEPTH and floors at 0.
- Error pulses are registered and last exactly one cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state is inserted after bit 7 and samples one bit after D clocks. Even parity: XOR of the 8 data bits and the parity bit must be 0.
  - Mismatch: parity_err pulses one cycle after the stop sample, and the byte is not pushed. frame_err still takes precedence for the next-state choice.
- Undefined:
  - No PARITY state; 8N1 only.
  - parity_err is tied to 0.

Test Plan:
- cfg_div=0, send 0x55 then 0xA3 at 106 clocks/bit, rx_ready=1 -> rx_valid rises 1 cycle after each stop sample; rx_data 0x55 then 0xA3; no error pulses.
- ser_rx low for 20 cycles then high, cfg_div=106 -> FSM returns to IDLE; rx_valid stays 0; no frame_err.
- Frame 0x3C with stop bit 0, line high 2 bits later -> single frame_err pulse; fifo_level stays 0; next valid frame 0x7E is received correctly.
- rx_ready=0, send 17 bytes 0x00..0x10 -> fifo_level=16; one overrun pulse on byte 0x10; draining yields 0x00..0x0F in order.
- Full FIFO, assert rx_ready on the exact stop-sample cycle of a 17th byte -> no overrun; level stays 16; tail entry holds the new byte.
- reset asserted for 1 cycle during bit 4 of a frame -> all outputs at reset values; next full frame 0x81 is received intact.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> accepted; with parity bit 0 -> parity_err pulse and no push.
